// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - MEM-stage sequencer serializing vector/scalar loads and stores onto one element-wide memory port
//
// Purpose: takes a load/store from the EX/MEM register, issues one memory
// request per element (R for a vector, 1 for a scalar), stalls the pipeline
// until all elements are done and gathers load elements into rdata_m.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   valid_m, mem_write_m,         instruction handoff from EX/MEM
//   mem_to_reg_m, vsi_flag_m,
//   address_m, wdata_m
//   stall                         freeze upstream stages
//   mem_req, mem_we, mem_addr,    element request to data memory
//   mem_wdata, mem_ack, mem_rdata
//   rdata_m, rdata_valid          gathered load data and completion pulse
module vector_mem_sequencer #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid_m,
  input  logic           mem_write_m,
  input  logic           mem_to_reg_m,
  input  logic [1:0]     vsi_flag_m,
  input  logic [I-1:0]   address_m,
  input  logic [R*N-1:0] wdata_m,
  output logic           stall,
  output logic           mem_req,
  output logic           mem_we,
  output logic [I-1:0]   mem_addr,
  output logic [N-1:0]   mem_wdata,
  input  logic           mem_ack,
  input  logic [N-1:0]   mem_rdata,
  output logic [R*N-1:0] rdata_m,
  output logic           rdata_valid
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [I-1:0]     base;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    last_idx;   // cnt-1: R-1 for a vector, 0 for a scalar
  logic             we;
  logic [R*N-1:0]   wdata_l;

  logic             start;
  logic             is_vec;
  logic [IW-1:0]    idx_nxt;

  assign start   = valid_m & (mem_write_m | mem_to_reg_m);
  assign is_vec  = (vsi_flag_m == 2'b01);
  assign idx_nxt = idx + IW'(1);

  // A new start is only honoured outside BUSY, so stall from start is
  // gated the same way the FSM gates it.
  assign stall = (state == BUSY) | (start & (state != BUSY));

  function automatic logic [N-1:0] lane_of(input logic [R*N-1:0] v, input logic [IW-1:0] i);
    lane_of = '0;
    for (int k = 0; k < R; k++) begin
      if (i == IW'(k)) lane_of = v[k*N +: N];
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      idx         <= '0;
      last_idx    <= '0;
      we          <= 1'b0;
      wdata_l     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata_m     <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Store wins when both load and store flags are set.
            base      <= address_m;
            wdata_l   <= wdata_m;
            we        <= mem_write_m;
            last_idx  <= is_vec ? IW'(R - 1) : '0;
            idx       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= mem_write_m;
            mem_addr  <= address_m;
            mem_wdata <= wdata_m[N-1:0];
            if (!mem_write_m && !is_vec) begin
              for (int k = 1; k < R; k++) rdata_m[k*N +: N] <= '0;
            end
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!we) begin
              for (int k = 0; k < R; k++) begin
                if (idx == IW'(k)) rdata_m[k*N +: N] <= mem_rdata;
              end
            end
            if (idx == last_idx) begin
              mem_req     <= 1'b0;
              mem_we      <= 1'b0;
              rdata_valid <= ~we;
              state       <= DONE;
            end else begin
              // Address wraps modulo 2^I by plain truncation.
              idx       <= idx_nxt;
              mem_addr  <= base + {{(I-IW){1'b0}}, idx_nxt};
              mem_wdata <= lane_of(wdata_l, idx_nxt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb/tb_vector_mem_sequencer.sv - directed self-checking bench for vector_mem_sequencer
module tb_vector_mem_sequencer;
  localparam int I = 32;
  localparam int N = 8;
  localparam int R = 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           valid_m, mem_write_m, mem_to_reg_m;
  logic [1:0]     vsi_flag_m;
  logic [I-1:0]   address_m;
  logic [R*N-1:0] wdata_m;
  logic           stall, mem_req, mem_we, mem_ack, rdata_valid;
  logic [I-1:0]   mem_addr;
  logic [N-1:0]   mem_wdata, mem_rdata;
  logic [R*N-1:0] rdata_m;

  int total = 0;
  int bad = 0;

  int        wait_cycles = 0;
  int        wait_cnt;
  logic [7:0] rd_off = 8'h00;
  int        stall_cnt, req_cnt, rv_cnt;
  logic [I-1:0] log_addr[$];
  logic [N-1:0] log_data[$];
  logic         log_we[$];

  vector_mem_sequencer #(.I(I), .N(N), .R(R)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .mem_write_m(mem_write_m),
    .mem_to_reg_m(mem_to_reg_m), .vsi_flag_m(vsi_flag_m), .address_m(address_m),
    .wdata_m(wdata_m), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rdata_m(rdata_m), .rdata_valid(rdata_valid)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after wait_cycles idle cycles per element.
  assign mem_ack   = mem_req && (wait_cnt >= wait_cycles);
  assign mem_rdata = mem_addr[7:0] + rd_off;

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(valid_m && mem_req)) else $error("protocol violation: valid_m while busy");
      if (stall) stall_cnt++;
      if (mem_req) req_cnt++;
      if (rdata_valid) rv_cnt++;
      if (mem_req && mem_ack) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_we ? mem_wdata : mem_rdata);
        log_we.push_back(mem_we);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    stall_cnt = 0; req_cnt = 0; rv_cnt = 0;
    log_addr.delete(); log_data.delete(); log_we.delete();
  endtask

  task automatic start_op(input logic w, input logic l, input logic [1:0] v,
                          input logic [I-1:0] a, input logic [R*N-1:0] d);
    valid_m = 1'b1; mem_write_m = w; mem_to_reg_m = l; vsi_flag_m = v;
    address_m = a; wdata_m = d;
    tick();
    valid_m = 1'b0; mem_write_m = 1'b0; mem_to_reg_m = 1'b0;
  endtask

  // Runs until the DONE cycle has been observed and the FSM is back in IDLE.
  task automatic wait_done(input int max);
    int n = 0;
    while ((mem_req || stall) && n < max) begin tick(); n++; end
    total++;
    if (n >= max) begin bad++; $display("FAIL wait_done timeout after %0d cycles", n); end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_m = 1'b0; mem_write_m = 1'b0; mem_to_reg_m = 1'b0;
    vsi_flag_m = 2'b00; address_m = '0; wdata_m = '0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b exp 0", stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b exp 0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    total++; if (rdata_m !== 48'h0) begin bad++; $display("FAIL reset_rdata got %h exp 0", rdata_m); end
    total++; if (rdata_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b exp 0", rdata_valid); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_vector_store();
    clear_logs(); wait_cycles = 0;
    valid_m = 1'b1; mem_write_m = 1'b1; mem_to_reg_m = 1'b0; vsi_flag_m = 2'b01;
    address_m = 32'h100; wdata_m = 48'h665544332211;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL vst_start_stall got %b exp 1", stall); end
    tick();
    valid_m = 1'b0; mem_write_m = 1'b0;
    wait_done(30);
    total++; if (log_addr.size() != 6) begin bad++; $display("FAIL vst_count got %0d exp 6", log_addr.size()); end
    for (int k = 0; k < log_addr.size() && k < 6; k++) begin
      total++;
      if (log_addr[k] !== 32'h100 + k || log_data[k] !== 8'((k + 1) * 17) || log_we[k] !== 1'b1) begin
        bad++; $display("FAIL vst_elem%0d got a=%h d=%h we=%b exp a=%h d=%h we=1", k, log_addr[k], log_data[k], log_we[k], 32'h100 + k, 8'((k + 1) * 17));
      end
    end
    total++; if (stall_cnt != 7) begin bad++; $display("FAIL vst_stall_cycles got %0d exp 7", stall_cnt); end
    total++; if (rv_cnt != 0) begin bad++; $display("FAIL vst_rvalid got %0d exp 0", rv_cnt); end
  endtask

  task automatic test_vector_load_wrap();
    logic [I-1:0] ea;
    clear_logs(); wait_cycles = 0; rd_off = 8'h10;
    start_op(1'b0, 1'b1, 2'b01, 32'hFFFF_FFFE, '0);
    wait_done(30);
    total++; if (log_addr.size() != 6) begin bad++; $display("FAIL vld_count got %0d exp 6", log_addr.size()); end
    for (int k = 0; k < log_addr.size() && k < 6; k++) begin
      ea = 32'hFFFF_FFFE + k;
      total++;
      if (log_addr[k] !== ea || log_we[k] !== 1'b0) begin
        bad++; $display("FAIL vld_addr%0d got %h we=%b exp %h we=0", k, log_addr[k], log_we[k], ea);
      end
    end
    total++; if (rdata_m !== 48'h131211100F0E) begin bad++; $display("FAIL vld_rdata got %h exp 131211100f0e", rdata_m); end
    total++; if (rv_cnt != 1) begin bad++; $display("FAIL vld_rvalid got %0d exp 1", rv_cnt); end
  endtask

  task automatic test_scalar_load_wait();
    clear_logs(); wait_cycles = 3; rd_off = 8'h85;
    start_op(1'b0, 1'b1, 2'b00, 32'h20, '0);
    wait_done(30);
    total++; if (req_cnt != 4) begin bad++; $display("FAIL sld_req_cycles got %0d exp 4", req_cnt); end
    total++; if (stall_cnt != 5) begin bad++; $display("FAIL sld_stall_cycles got %0d exp 5", stall_cnt); end
    total++; if (log_addr.size() != 1 || log_addr[0] !== 32'h20) begin bad++; $display("FAIL sld_addr got n=%0d exp one access at 20", log_addr.size()); end
    total++; if (rdata_m !== 48'h0000000000A5) begin bad++; $display("FAIL sld_rdata got %h exp 0000000000a5", rdata_m); end
    total++; if (rv_cnt != 1) begin bad++; $display("FAIL sld_rvalid got %0d exp 1", rv_cnt); end
    wait_cycles = 0;
  endtask

  task automatic test_reset_mid();
    clear_logs(); wait_cycles = 0; rd_off = 8'h00;
    start_op(1'b1, 1'b0, 2'b01, 32'h200, 48'h665544332211);
    tick(); tick();
    total++; if (mem_addr !== 32'h202) begin bad++; $display("FAIL rst_third_addr got %h exp 202", mem_addr); end
    reset = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rst_same_cycle got req=%b stall=%b exp 0 0", mem_req, stall); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 8'h0 || rdata_m !== 48'h0) begin bad++; $display("FAIL rst_regs got a=%h d=%h r=%h exp 0", mem_addr, mem_wdata, rdata_m); end
    total++; if (log_addr.size() != 2) begin bad++; $display("FAIL rst_writes got %0d exp 2", log_addr.size()); end
    tick();
    reset = 1'b0;
    tick();
    clear_logs();
    start_op(1'b0, 1'b1, 2'b01, 32'h40, '0);
    total++; if (mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL rst_restart got a=%h we=%b req=%b exp 40 0 1", mem_addr, mem_we, mem_req); end
    wait_done(30);
    total++; if (rdata_m !== 48'h454443424140) begin bad++; $display("FAIL rst_reload got %h exp 454443424140", rdata_m); end
    total++; if (rv_cnt != 1) begin bad++; $display("FAIL rst_rvalid got %0d exp 1", rv_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_logs(); wait_cycles = 0; rd_off = 8'h20;
    start_op(1'b1, 1'b0, 2'b00, 32'h300, 48'h000000000077);
    tick();
    total++; if (mem_req !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0) begin bad++; $display("FAIL b2b_done got req=%b stall=%b rv=%b exp 0 0 0", mem_req, stall, rdata_valid); end
    total++; if (rdata_m !== 48'h454443424140) begin bad++; $display("FAIL b2b_store_keeps got %h exp 454443424140", rdata_m); end
    valid_m = 1'b1; mem_to_reg_m = 1'b1; vsi_flag_m = 2'b01; address_m = 32'h310;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_start_stall got %b exp 1", stall); end
    tick();
    valid_m = 1'b0; mem_to_reg_m = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h310) begin bad++; $display("FAIL b2b_busy got req=%b we=%b a=%h exp 1 0 310", mem_req, mem_we, mem_addr); end
    wait_done(30);
    total++; if (log_addr.size() != 7 || log_addr[0] !== 32'h300 || log_data[0] !== 8'h77 || log_we[0] !== 1'b1) begin bad++; $display("FAIL b2b_store got n=%0d exp 7 accesses first store 77 at 300", log_addr.size()); end
    total++; if (rdata_m !== 48'h353433323130) begin bad++; $display("FAIL b2b_rdata got %h exp 353433323130", rdata_m); end
    total++; if (stall_cnt != 9) begin bad++; $display("FAIL b2b_stall_cycles got %0d exp 9", stall_cnt); end
    total++; if (rv_cnt != 1) begin bad++; $display("FAIL b2b_rvalid got %0d exp 1", rv_cnt); end
  endtask

  initial begin
    test_reset();
    test_vector_store();
    test_vector_load_wrap();
    test_scalar_load_wait();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
